// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-digit LED driver for the frequency counter's BCD digits.
// Frame-synchronous snapshot, leading-zero blanking, decimal point, ghost blanking.
module bcd_seg_scan #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLANK_CYC   = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] p1,
  input  logic [3:0] p2,
  input  logic [3:0] p3,
  input  logic [3:0] p4,
  input  logic [3:0] p5,
  input  logic [3:0] p6,
  input  logic [3:0] p7,
  input  logic       load,
  input  logic       blank_en,
  input  logic [2:0] dp_pos,
  output logic [7:0] seg,
  output logic [6:0] sel
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [7:0] SEG_MASK = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0] SEL_MASK = (SEL_ACT_LOW != 0) ? 7'h7F : 7'h00;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          pending;
  logic [3:0]    snap [7];
  logic [2:0]    snap_dp;
  logic [3:0]    p_in [7];
  logic          frame_end;

  logic [3:0] cur;
  logic       lead_zero;
  logic       blank;
  logic       dp_on;
  logic [6:0] glyph;
  logic [7:0] seg_act;
  logic [6:0] sel_act;

  assign p_in[0] = p1;
  assign p_in[1] = p2;
  assign p_in[2] = p3;
  assign p_in[3] = p4;
  assign p_in[4] = p5;
  assign p_in[5] = p6;
  assign p_in[6] = p7;

  assign frame_end = (cnt == CNT_LAST) && (idx == 3'd6);

  always_comb begin
    cur       = 4'h0;
    lead_zero = 1'b1;
    // Prefix scan: the current digit and everything left of it must be zero to blank.
    for (int i = 0; i < 7; i++) begin
      if (3'(i) <= idx) begin
        if (snap[i] != 4'h0) lead_zero = 1'b0;
        if (3'(i) == idx)    cur = snap[i];
      end
    end
    case (cur)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
    dp_on = (snap_dp != 3'd0) && ({1'b0, snap_dp} == ({1'b0, idx} + 4'd1));
    blank = blank_en && lead_zero && (idx != 3'd6) &&
            ((snap_dp == 3'd0) || (({1'b0, idx} + 4'd1) < {1'b0, snap_dp}));
    seg_act = blank ? 8'h00 : {dp_on, glyph};
    sel_act = 7'b1 << idx;
    if (cnt < CNT_BLANK) begin
      seg_act = 8'h00;
      sel_act = 7'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 3'd0;
      pending <= 1'b0;
      snap_dp <= 3'd0;
      for (int i = 0; i < 7; i++) snap[i] <= 4'h0;
      seg     <= SEG_MASK;
      sel     <= SEL_MASK;
    end else begin
      seg <= seg_act ^ SEG_MASK;
      sel <= sel_act ^ SEL_MASK;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == 3'd6) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A load coinciding with frame end is captured directly without touching pending.
      if (frame_end && (pending || load)) begin
        for (int i = 0; i < 7; i++) snap[i] <= p_in[i];
        snap_dp <= dp_pos;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: a frame-level display model predicts each
// cycle's seg/sel, a monitor compares the DUT against the queued predictions.
module tb_bcd_seg_scan;

  localparam int DIV   = 10;
  localparam int FRAME = 7 * DIV;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] p [7];
  logic       load = 1'b0;
  logic       blank_en = 1'b1;
  logic [2:0] dp_pos = 3'd0;
  logic [7:0] seg;
  logic [6:0] sel;

  typedef struct {
    logic [7:0] seg;
    logic [6:0] sel;
    int         tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick     = 0;
  bit   m_pend   = 0;
  int   m_d [7];
  int   m_dp     = 0;

  bcd_seg_scan #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(BLANK),
    .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p1(p[0]), .p2(p[1]), .p3(p[2]), .p4(p[3]), .p5(p[4]), .p6(p[5]), .p7(p[6]),
    .load(load), .blank_en(blank_en), .dp_pos(dp_pos),
    .seg(seg), .sel(sel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph_of(int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference: which digit is lit at tick t, and what the captured frame looks like there.
  always @(posedge clk) begin
    if (!rst_n) begin
      tick   = 0;
      m_pend = 0;
      m_dp   = 0;
      foreach (m_d[i]) m_d[i] = 0;
      exp_q.delete();
    end else begin
      exp_t e;
      int   slot_pos, k, first_nz;
      logic [7:0] act;
      slot_pos = tick % DIV;
      k        = (tick / DIV) % 7 + 1;
      first_nz = 8;
      for (int i = 7; i >= 1; i--) if (m_d[i-1] != 0) first_nz = i;
      if (slot_pos < BLANK) begin
        e.seg = 8'hFF;
        e.sel = 7'h7F;
      end else begin
        if (blank_en && k < first_nz && k < 7 && (m_dp == 0 || k < m_dp))
          act = 8'h00;
        else
          act = {(k == m_dp), glyph_of(m_d[k-1])};
        e.seg = ~act;
        e.sel = ~(7'(1) << (k - 1));
      end
      e.tick = tick;
      exp_q.push_back(e);
      if (tick % FRAME == FRAME - 1) begin
        if (m_pend || load) begin
          for (int i = 0; i < 7; i++) m_d[i] = int'(p[i]);
          m_dp   = int'(dp_pos);
          m_pend = 0;
        end
      end else if (load) begin
        m_pend = 1;
      end
      tick++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      n_checks++;
      if (seg !== 8'hFF || sel !== 7'h7F) begin
        n_fail++;
        $display("FAIL reset_out: seg=%h sel=%h, want seg=ff sel=7f", seg, sel);
      end
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: no prediction for seg=%h sel=%h", seg, sel);
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (seg !== e.seg || sel !== e.sel) begin
        n_fail++;
        $display("FAIL scan_t%0d: seg=%h sel=%h, want seg=%h sel=%h",
                 e.tick, seg, sel, e.seg, e.sel);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic set_p(int a, int b, int c, int d, int e, int f, int g);
    p[0] = 4'(a); p[1] = 4'(b); p[2] = 4'(c); p[3] = 4'(d);
    p[4] = 4'(e); p[5] = 4'(f); p[6] = 4'(g);
  endtask

  task automatic wait_phase(int ph, string name);
    int guard = 0;
    while (tick % FRAME != ph && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (tick % FRAME != ph) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: phase=%0d, want %0d", name, tick % FRAME, ph);
    end
  endtask

  initial begin
    set_p(0, 0, 0, 0, 0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2 * FRAME);

    set_p(0, 0, 1, 2, 3, 4, 5);
    pulse_load();
    cyc(2 * FRAME);

    wait_phase(20, "midframe");
    set_p(9, 9, 9, 9, 9, 9, 9);
    pulse_load();
    cyc(2 * FRAME);

    set_p(1, 1, 1, 12, 1, 1, 1);
    pulse_load();
    cyc(2 * FRAME);

    set_p(0, 0, 0, 0, 0, 0, 0);
    dp_pos = 3'd5;
    pulse_load();
    cyc(2 * FRAME);
    blank_en = 1'b0;
    cyc(FRAME);
    blank_en = 1'b1;

    // Frame-end coincident load, then a burst of loads collapsing into one capture.
    wait_phase(FRAME - 1, "fe_load");
    set_p(3, 1, 4, 1, 5, 9, 2);
    dp_pos = 3'd2;
    pulse_load();
    cyc(FRAME);
    pulse_load();
    set_p(0, 0, 7, 0, 0, 0, 8);
    pulse_load();
    dp_pos = 3'd0;
    cyc(2 * FRAME);

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 29) == 0)
        for (int i = 0; i < 7; i++)
          p[i] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) dp_pos = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) blank_en = ~blank_en;
      load = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    load = 1'b0;

    set_p(8, 8, 8, 8, 8, 8, 8);
    blank_en = 1'b0;
    pulse_load();
    cyc(FRAME);
    pulse_load();
    wait_phase(3 * DIV + 5, "rst_phase");
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (seg !== 8'hFF || sel !== 7'h7F) begin
      n_fail++;
      $display("FAIL async_reset: seg=%h sel=%h, want seg=ff sel=7f", seg, sel);
    end
    cyc(2);
    blank_en = 1'b1;
    rst_n = 1'b1;
    cyc(2 * FRAME);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
